timer_counter: RTL and testbench

- Memory-mapped programmable timer on the system bridge, directly downstream of the CPU's PrAddr/PrWD/PrWe/PrRD bus.
- Produces the interrupt request that drives one bit of the CPU's HWInt[7:2] input.
- Bridge decodes the device window and presents a word address plus a write strobe. The timer returns read data combinationally.
- Three registers: CTRL (0x0), PRESET (0x4), COUNT (0x8).

---
 rtl/timer_counter.sv | 145 ++++++++++++++
 tb/tb_timer_counter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter with interrupt (CTRL/PRESET/COUNT).
// Define TIMER_PRESCALE_EN to divide the count rate by PRESCALE.
module timer_counter #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CTRL_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_t;

   state_t              state, state_n;
   logic [CTRL_W-1:0]   ctrl, ctrl_n;
   logic [DATA_W-1:0]   preset, preset_n;
   logic [DATA_W-1:0]   count, count_n;
   logic                ir_flag, ir_flag_n;
   logic                tick;
   logic                en;
   logic                auto_reload;
   logic                im;

   assign en          = ctrl[0];
   assign auto_reload = (ctrl[2:1] == 2'b01);
   assign im          = ctrl[3];

`ifdef TIMER_PRESCALE_EN
   localparam int unsigned DIV_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PRESCALE - 1);

   logic [DIV_W-1:0] div;

   assign tick = (div == DIV_MAX);

   // Divider only advances while actively counting; cleared everywhere else.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         div <= '0;
      else if (state != CNT)
         div <= '0;
      else if (en)
         div <= tick ? '0 : div + DIV_W'(1);
   end
`else
   // PRESCALE is ignored here; any legal value makes this a constant 1.
   assign tick = (PRESCALE != 0);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         ctrl    <= '0;
         preset  <= '0;
         count   <= '0;
         ir_flag <= 1'b0;
      end else begin
         state   <= state_n;
         ctrl    <= ctrl_n;
         preset  <= preset_n;
         count   <= count_n;
         ir_flag <= ir_flag_n;
      end
   end

   // FSM step first, then bus writes so software wins same-edge conflicts.
   always_comb begin
      state_n   = state;
      ctrl_n    = ctrl;
      preset_n  = preset;
      count_n   = count;
      ir_flag_n = ir_flag;

      case (state)
         IDLE: begin
            if (en) state_n = LOAD;
         end
         LOAD: begin
            count_n = preset;
            state_n = CNT;
         end
         CNT: begin
            if (!en) begin
               state_n = IDLE;
            end else if (tick) begin
               if (count > DATA_W'(1)) begin
                  count_n = count - DATA_W'(1);
               end else begin
                  count_n   = '0;
                  ir_flag_n = 1'b1;
                  state_n   = INT;
               end
            end
         end
         INT: begin
            if (auto_reload) begin
               ir_flag_n = 1'b0;
               state_n   = LOAD;
            end else begin
               ctrl_n[0] = 1'b0;
               state_n   = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      if (we) begin
         case (addr)
            2'd0: begin
               ctrl_n    = din[CTRL_W-1:0];
               ir_flag_n = 1'b0;
            end
            2'd1: begin
               preset_n  = din;
               ir_flag_n = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      dout = '0;
      case (addr)
         2'd0:    dout = {(DATA_W-CTRL_W)'(0), ctrl};
         2'd1:    dout = preset;
         2'd2:    dout = count;
         default: dout = '0;
      endcase
   end

   assign irq = ir_flag & im;

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter; inputs change on the
// falling edge, outputs are sampled just after it.
module tb_timer_counter;

   logic        clk;
   logic        reset;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] din;
   logic [31:0] dout;
   logic        irq;

   int unsigned errors = 0;
   int unsigned checks = 0;

   timer_counter #(.PRESCALE(4)) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .din   (din),
      .dout  (dout),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check(tag, dout, exp);
   endtask

   task automatic cnt(input string tag, input logic [31:0] c, input logic i);
      rd(tag, 2'd2, c);
      check({tag, "_irq"}, {31'b0, irq}, {31'b0, i});
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Write lands on the next rising edge; returns on the following falling edge.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      addr = a;
      din  = d;
      we   = 1'b1;
      @(negedge clk);
      we   = 1'b0;
   endtask

   logic [31:0] os_cnt [5] = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0};
   logic        os_irq [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [31:0] ar_cnt [9] = '{32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0, 32'd0};
   logic        ar_irq [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      reset = 1'b1;
      we    = 1'b0;
      addr  = 2'd0;
      din   = '0;
      step(2);
      check("rst_irq", {31'b0, irq}, 32'd0);
      rd("rst_ctrl", 2'd0, 32'd0);
      rd("rst_count", 2'd2, 32'd0);
      step(1);
      reset = 1'b0;
      for (int a = 0; a < 4; a++) rd("post_rst_rd", 2'(a), 32'd0);
      check("post_rst_irq", {31'b0, irq}, 32'd0);

`ifdef TIMER_PRESCALE_EN
      // PRESCALE=4, PRESET=2, one-shot: irq after t0+2+2*4
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h9);
      for (int k = 1; k <= 10; k++) begin
         step(1);
         cnt("ps", (k == 1) ? 32'd0 : (k <= 5) ? 32'd2 : (k <= 9) ? 32'd1 : 32'd0, k == 10);
      end
      step(1);
      rd("ps_ctrl", 2'd0, 32'h8);
      check("ps_irq_hold", {31'b0, irq}, 32'd1);
`else
      // One-shot, PRESET=3, IM set
      wr(2'd1, 32'd3);
      wr(2'd0, 32'h9);
      rd("os_ctrl", 2'd0, 32'h9);
      cnt("os_t0", 32'd0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step(1);
         cnt("os", os_cnt[k], os_irq[k]);
      end
      step(1);
      rd("os_ctrl_en_clr", 2'd0, 32'h8);
      check("os_irq_held", {31'b0, irq}, 32'd1);
      step(3);
      check("os_irq_held2", {31'b0, irq}, 32'd1);
      wr(2'd1, 32'd5);
      check("os_irq_clr", {31'b0, irq}, 32'd0);
      rd("os_preset", 2'd1, 32'd5);

      // CTRL write during INT keeps EN; PRESET write beats flag set
      wr(2'd1, 32'd1);
      wr(2'd0, 32'h9);
      step(1); cnt("sim_a", 32'd0, 1'b0);
      step(1); cnt("sim_b", 32'd1, 1'b0);
      step(1); cnt("sim_c", 32'd0, 1'b1);
      wr(2'd0, 32'h9);
      rd("sim_ctrl_kept", 2'd0, 32'h9);
      check("sim_irq_clr", {31'b0, irq}, 32'd0);
      step(2); cnt("sim_reload", 32'd1, 1'b0);
      wr(2'd1, 32'd1);
      cnt("sim_wr_wins", 32'd0, 1'b0);
      step(1);
      rd("sim_ctrl_final", 2'd0, 32'h8);
      check("sim_irq_final", {31'b0, irq}, 32'd0);

      // PRESET=0, IM clear: terminates but irq stays low
      wr(2'd1, 32'd0);
      wr(2'd0, 32'h1);
      for (int k = 1; k <= 3; k++) begin
         step(1);
         cnt("p0", 32'd0, 1'b0);
      end
      step(1);
      rd("p0_ctrl", 2'd0, 32'h0);

      // Auto-reload, PRESET=2: one-cycle irq pulse every 4 cycles
      wr(2'd1, 32'd2);
      wr(2'd0, 32'hB);
      for (int k = 0; k < 9; k++) begin
         step(1);
         cnt("ar", ar_cnt[k], ar_irq[k]);
      end
      wr(2'd0, 32'h0);
      step(1);

      // Freeze mid-count at 5, then reload from new PRESET
      wr(2'd1, 32'd8);
      wr(2'd0, 32'h1);
      step(4);
      cnt("fr_pre", 32'd6, 1'b0);
      wr(2'd0, 32'h0);
      for (int k = 0; k < 10; k++) begin
         cnt("fr_hold", 32'd5, 1'b0);
         step(1);
      end
      wr(2'd1, 32'd7);
      wr(2'd0, 32'h1);
      cnt("fr_t1", 32'd5, 1'b0);
      step(2);
      cnt("fr_reload", 32'd7, 1'b0);
      wr(2'd1, 32'd2);
      cnt("fr_preset_nodisturb", 32'd6, 1'b0);

      // Asynchronous reset mid-count
      reset = 1'b1;
      cnt("mid_rst", 32'd0, 1'b0);
      step(1);
      reset = 1'b0;
      rd("mid_rst_ctrl", 2'd0, 32'd0);
      rd("mid_rst_preset", 2'd1, 32'd0);
      step(3);
      cnt("mid_rst_idle", 32'd0, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
